// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Optional feature macro: MC_CTRL_ADDI_EN (adds the addi execute/write-back states).
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_ALU_WB,
        S_BRANCH,
`ifdef MC_CTRL_ADDI_EN
        S_ADDI_EXEC,
        S_ADDI_WB,
`endif
        S_JUMP
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       rw;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decode (Moore outputs).
// Optional feature macro: MC_CTRL_ADDI_EN.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    // One control word per state; anything not set stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC,
`endif
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.iord = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.rw         = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.rw      = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_WB: begin
                ctrl.rw = 1'b1;
            end
`endif
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register, sequencing, illegal flag and retire counter.
// Optional feature macro: MC_CTRL_ADDI_EN (opcode 0x08 executes as addi; otherwise illegal).
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_write,
    output logic             branch,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             rw,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t     state;
    ctrl_word_t ctrl;

    // The branch decision (branch & zero) is made in the datapath
    logic unused_zero;
    assign unused_zero = zero;

    // State sequencing, one-cycle illegal pulse and retired-instruction count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                        OP_ADDI:      state <= S_ADDI_EXEC;
`endif
                        default: begin
                            state   <= S_FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:  state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  state <= S_MEM_WB;
                S_EXECUTE:   state <= S_ALU_WB;
`ifdef MC_CTRL_ADDI_EN
                S_ADDI_EXEC: state <= S_ADDI_WB;
                S_ADDI_WB,
`endif
                S_MEM_WB,
                S_MEM_WRITE,
                S_ALU_WB,
                S_BRANCH,
                S_JUMP: begin
                    state     <= S_FETCH;
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign rw         = ctrl.rw;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (CNT_W=4 to exercise counter wrap).
// Honors MC_CTRL_ADDI_EN to pick the expected addi behaviour.
module tb_multicycle_control_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic             zero;
    logic             pc_write, branch, iord, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, rw, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_src;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    multicycle_control_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .rw         (rw),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: {pw, br, iord, mw, irw, rd, m2r, rw, asa, asb, aop, psrc}
    logic [14:0] obs;
    assign obs = {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                  rw, alu_src_a, alu_src_b, alu_op, pc_src};

    localparam logic [14:0] W_0    = 15'h0;
    localparam logic [14:0] W_F    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
    localparam logic [14:0] W_D    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
    localparam logic [14:0] W_MA   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
    localparam logic [14:0] W_MR   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_MWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_MW   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_EX   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
    localparam logic [14:0] W_AWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_IWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [14:0] W_BR   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
    localparam logic [14:0] W_J    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic            z;
        int              len;
        logic [4:0][14:0] w;
        logic            ill;
        logic            cnt;
    } vec_t;

    vec_t        tab [9];
    logic [15:0] sb [$];
    int          n_cmp;
    int          n_err;
    logic [CNT_W-1:0] exp_cnt;
    logic        prev_ill;

    function automatic logic [4:0][14:0] seq(input logic [14:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; pushes expected per-cycle words, then pops/compares one per cycle
    task automatic run_instr(input int i);
        logic [15:0] item;
        opcode = tab[i].op;
        zero   = tab[i].z;
        for (int c = 0; c < tab[i].len; c++)
            sb.push_back({tab[i].w[c], (c == 0) ? prev_ill : 1'b0});
        for (int c = 0; c < tab[i].len; c++) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s c%0d: scoreboard empty", tab[i].name, c);
            end else begin
                item = sb.pop_front();
                check($sformatf("%s c%0d word", tab[i].name, c), 32'(obs), 32'(item[15:1]));
                check($sformatf("%s c%0d illegal", tab[i].name, c), 32'(illegal), 32'(item[0]));
                check($sformatf("%s c%0d cnt", tab[i].name, c), 32'(instr_cnt), 32'(exp_cnt));
            end
            step();
        end
        if (tab[i].cnt) exp_cnt = exp_cnt + CNT_W'(1);
        prev_ill = tab[i].ill;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_cnt  = '0;
        prev_ill = 1'b0;
        rst      = 1'b0;
        opcode   = 6'h00;
        zero     = 1'b0;

        tab[0] = '{"lw",    6'h23, 1'b0, 5, seq(W_F, W_D, W_MA, W_MR, W_MWB), 1'b0, 1'b1};
        tab[1] = '{"sw",    6'h2B, 1'b0, 4, seq(W_F, W_D, W_MA, W_MW, W_0),   1'b0, 1'b1};
        tab[2] = '{"rtype", 6'h00, 1'b0, 4, seq(W_F, W_D, W_EX, W_AWB, W_0),  1'b0, 1'b1};
        tab[3] = '{"beq_z1",6'h04, 1'b1, 3, seq(W_F, W_D, W_BR, W_0, W_0),    1'b0, 1'b1};
        tab[4] = '{"beq_z0",6'h04, 1'b0, 3, seq(W_F, W_D, W_BR, W_0, W_0),    1'b0, 1'b1};
        tab[5] = '{"j",     6'h02, 1'b0, 3, seq(W_F, W_D, W_J, W_0, W_0),     1'b0, 1'b1};
        tab[6] = '{"ill3f", 6'h3F, 1'b0, 2, seq(W_F, W_D, W_0, W_0, W_0),     1'b1, 1'b0};
`ifdef MC_CTRL_ADDI_EN
        tab[7] = '{"addi",  6'h08, 1'b0, 4, seq(W_F, W_D, W_MA, W_IWB, W_0),  1'b0, 1'b1};
`else
        tab[7] = '{"addi",  6'h08, 1'b0, 2, seq(W_F, W_D, W_0, W_0, W_0),     1'b1, 1'b0};
`endif
        tab[8] = '{"rtype2",6'h00, 1'b0, 4, seq(W_F, W_D, W_EX, W_AWB, W_0),  1'b0, 1'b1};

        // Reset held across clock edges: everything zero
        #12;
        check("reset word", 32'(obs), 32'(W_0));
        check("reset illegal", 32'(illegal), 32'h0);
        check("reset cnt", 32'(instr_cnt), 32'h0);

        // Release away from the edge: IDLE until the next rising edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle word", 32'(obs), 32'(W_0));
        step();

        for (int i = 0; i < 9; i++) run_instr(i);

        // Reset asserted mid-lw while in MEM_READ
        opcode = 6'h23;
        step();
        step();
        step();
        check("pre-reset memread", 32'(obs), 32'(W_MR));
        rst = 1'b0;
        #1;
        check("abort word", 32'(obs), 32'(W_0));
        check("abort cnt", 32'(instr_cnt), 32'h0);
        check("abort illegal", 32'(illegal), 32'h0);
        step();
        check("abort held word", 32'(obs), 32'(W_0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort idle word", 32'(obs), 32'(W_0));
        step();
        exp_cnt  = '0;
        prev_ill = 1'b0;

        // Counter wrap: 15 R-types reach all-ones, the 16th wraps to zero
        for (int k = 0; k < 15; k++) run_instr(2);
        check("cnt all ones", 32'(instr_cnt), 32'hF);
        run_instr(2);
        check("cnt wrapped", 32'(instr_cnt), 32'h0);
        check("final fetch", 32'(obs), 32'(W_F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
